// File: rtl/regfile_pkg.sv
// Shared widths and the writeback holding-buffer entry type for the
// register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned ADDR_W = 4;

  // age is set on the younger of two co-resident entries
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              age;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two requester handshakes, the register
// file write port, the pending-write mask and the sticky WAW flag.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
);
  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   pending_mask;
  logic              waw_err;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending_mask, waw_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending_mask, waw_err
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer with ready generation and relative-age flag.
// With REGFILE_WB_ZERO_REG_EN defined, writes to register 0 are accepted but dropped.
module wb_slot
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              grant,
  input  logic              other_keep,
  output wb_entry_t         entry
);

  wb_entry_t entry_q, entry_d;
  logic      addr_ok;
  logic      load;

`ifdef REGFILE_WB_ZERO_REG_EN
  assign addr_ok = (in_addr != '0);
`else
  assign addr_ok = 1'b1;
`endif

  assign in_ready = ~entry_q.valid | grant;
  assign load     = in_valid & in_ready & addr_ok;
  assign entry    = entry_q;

  always_comb begin
    entry_d = entry_q;
    if (load) begin
      // younger than the other entry iff that entry survives this edge
      entry_d = '{valid: 1'b1, addr: in_addr, data: in_data, age: other_keep};
    end else if (grant) begin
      entry_d.valid = 1'b0;
      entry_d.age   = 1'b0;
    end else begin
      // once the older neighbour leaves, this entry is no longer the younger one
      entry_d.age = entry_q.age & other_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (port 0) and load (port 1) writebacks
// via age/round-robin arbitration. Optional: REGFILE_WB_ZERO_REG_EN (register 0 read-only).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  wb_entry_t         e0, e1;
  logic              g0, g1;
  logic              ready0, ready1;
  logic              rr_q, rr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              waw_q, waw_d;
  logic [NREG-1:0]   mask;

  wb_slot u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.req0_valid),
    .in_addr    (bus.req0_addr),
    .in_data    (bus.req0_data),
    .in_ready   (ready0),
    .grant      (g0),
    .other_keep (e1.valid & ~g1),
    .entry      (e0)
  );

  wb_slot u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.req1_valid),
    .in_addr    (bus.req1_addr),
    .in_data    (bus.req1_data),
    .in_ready   (ready1),
    .grant      (g1),
    .other_keep (e0.valid & ~g0),
    .entry      (e1)
  );

  // Older entry wins; the pointer only breaks ties between same-edge loads.
  always_comb begin
    g0   = 1'b0;
    g1   = 1'b0;
    rr_d = rr_q;
    if (e0.valid && e1.valid) begin
      if (e0.age != e1.age) begin
        g0 = ~e0.age;
        g1 = e0.age;
      end else begin
        g0   = ~rr_q;
        g1   = rr_q;
        rr_d = ~rr_q;
      end
    end else begin
      g0 = e0.valid;
      g1 = e1.valid;
    end
  end

  always_comb begin
    wr_en_d   = g0 | g1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case ({g1, g0})
      2'b01: begin
        wr_addr_d = e0.addr;
        wr_data_d = e0.data;
      end
      2'b10: begin
        wr_addr_d = e1.addr;
        wr_data_d = e1.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    waw_d = waw_q | (bus.req0_valid & ready0 & bus.req1_valid & ready1 &
                     (bus.req0_addr == bus.req1_addr));
  end

  always_comb begin
    mask = '0;
    if (e0.valid) mask[e0.addr] = 1'b1;
    if (e1.valid) mask[e1.addr] = 1'b1;
    if (wr_en_q)  mask[wr_addr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      waw_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      waw_q     <= waw_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pending_mask = mask;
  assign bus.waw_err      = waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: latency, alternation, age ordering, WAW,
// async reset and the optional REGFILE_WB_ZERO_REG_EN behaviour.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  regfile_wb_arbiter_if #(.DATA_W(18), .ADDR_W(4)) bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask, bus.waw_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%0b addr=%0h data=%0h mask=%0h waw=%0b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask, bus.waw_err);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 11", {bus.req0_ready, bus.req1_ready});
    end
    vectors++;
    if ({bus.wr_en, bus.pending_mask, bus.waw_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got en=%0b mask=%0h waw=%0b, want 0 0 0",
               bus.wr_en, bus.pending_mask, bus.waw_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd5;
    bus.req0_data  = 18'h2A5A;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready_pre: got %b, want 1", bus.req0_ready);
    end
    step();
    idle_inputs();
    vectors++;
    if ({bus.req0_ready, bus.wr_en, bus.pending_mask} !== {1'b1, 1'b0, 16'h0020}) begin
      miscompares++;
      $display("FAIL single_n1: got ready=%b en=%b mask=%h, want 1 0 0020",
               bus.req0_ready, bus.wr_en, bus.pending_mask);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask} !==
        {1'b1, 4'd5, 18'h2A5A, 16'h0020}) begin
      miscompares++;
      $display("FAIL single_n2: got en=%b addr=%0d data=%h mask=%h, want 1 5 2a5a 0020",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask} !==
        {1'b0, 4'd5, 18'h2A5A, 16'h0000}) begin
      miscompares++;
      $display("FAIL single_n3: got en=%b addr=%0d data=%h mask=%h, want 0 5 2a5a 0000",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    int idx0, idx1, nwr;
    bit t0, t1;
    logic [3:0]  exp_addr;
    logic [17:0] exp_data;
    do_reset();
    idx0 = 0;
    idx1 = 0;
    nwr  = 0;
    for (int cyc = 0; cyc < 40 && nwr < 16; cyc++) begin
      bus.req0_valid = (idx0 < 8);
      bus.req0_addr  = 4'd1;
      bus.req0_data  = 18'h00100 + 18'(idx0);
      bus.req1_valid = (idx1 < 8);
      bus.req1_addr  = 4'd2;
      bus.req1_data  = 18'h00200 + 18'(idx1);
      t0 = bus.req0_valid && bus.req0_ready;
      t1 = bus.req1_valid && bus.req1_ready;
      step();
      if (t0) idx0++;
      if (t1) idx1++;
      if (bus.wr_en === 1'b1) begin
        exp_addr = (nwr % 2 == 0) ? 4'd1 : 4'd2;
        exp_data = ((nwr % 2 == 0) ? 18'h00100 : 18'h00200) + 18'(nwr / 2);
        vectors++;
        if ({bus.wr_addr, bus.wr_data} !== {exp_addr, exp_data}) begin
          miscompares++;
          $display("FAIL b2b_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                   nwr, bus.wr_addr, bus.wr_data, exp_addr, exp_data);
        end
        nwr++;
      end else if (nwr > 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_gap: wr_en low after %0d writes, want continuous", nwr);
      end
    end
    idle_inputs();
    vectors++;
    if (nwr != 16) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d writes, want 16", nwr);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.pending_mask} !== '0) begin
      miscompares++;
      $display("FAIL b2b_drain: got en=%b mask=%h, want 0 0000", bus.wr_en, bus.pending_mask);
    end
  endtask

  // Columns: v0, a0, v1, a1, expected wr_en, expected wr_addr after the edge.
  // Row 4 loads port 0 behind an older port-1 entry while the pointer favours port 0.
  task automatic test_age();
    int tbl [11][6] = '{
      '{1, 10, 1, 11, 0,  0},
      '{0,  0, 0,  0, 1, 10},
      '{1, 12, 1, 13, 1, 11},
      '{0,  0, 1, 14, 1, 13},
      '{1,  4, 0,  0, 1, 12},
      '{0,  0, 1, 15, 1, 14},
      '{0,  0, 0,  0, 1,  4},
      '{1,  8, 1,  9, 1, 15},
      '{0,  0, 0,  0, 1,  8},
      '{0,  0, 0,  0, 1,  9},
      '{0,  0, 0,  0, 0,  9}
    };
    logic [17:0] exp_data;
    logic [3:0]  exp_addr;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      bus.req0_valid = tbl[k][0] != 0;
      bus.req0_addr  = 4'(tbl[k][1]);
      bus.req0_data  = 18'h10000 + 18'(tbl[k][1]);
      bus.req1_valid = tbl[k][2] != 0;
      bus.req1_addr  = 4'(tbl[k][3]);
      bus.req1_data  = 18'h10000 + 18'(tbl[k][3]);
      if (bus.req0_valid || bus.req1_valid) begin
        vectors++;
        if ({bus.req0_ready | ~bus.req0_valid, bus.req1_ready | ~bus.req1_valid} !== 2'b11) begin
          miscompares++;
          $display("FAIL age_ready%0d: got ready=%b%b for valid=%b%b", k,
                   bus.req0_ready, bus.req1_ready, bus.req0_valid, bus.req1_valid);
        end
      end
      step();
      exp_addr = 4'(tbl[k][5]);
      exp_data = (k == 0) ? 18'h0 : 18'h10000 + 18'(tbl[k][5]);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {(tbl[k][4] != 0), exp_addr, exp_data}) begin
        miscompares++;
        $display("FAIL age_step%0d: got en=%b addr=%0d data=%h, want en=%0d addr=%0d data=%h",
                 k, bus.wr_en, bus.wr_addr, bus.wr_data, tbl[k][4], exp_addr, exp_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_waw();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd7;
    bus.req0_data  = 18'h00001;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd7;
    bus.req1_data  = 18'h3FFFF;
    step();
    idle_inputs();
    vectors++;
    if ({bus.waw_err, bus.wr_en, bus.pending_mask} !== {1'b1, 1'b0, 16'h0080}) begin
      miscompares++;
      $display("FAIL waw_set: got waw=%b en=%b mask=%h, want 1 0 0080",
               bus.waw_err, bus.wr_en, bus.pending_mask);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.waw_err} !== {1'b1, 4'd7, 18'h00001, 1'b1}) begin
      miscompares++;
      $display("FAIL waw_first: got en=%b addr=%0d data=%h waw=%b, want 1 7 00001 1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.waw_err);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.waw_err} !== {1'b1, 4'd7, 18'h3FFFF, 1'b1}) begin
      miscompares++;
      $display("FAIL waw_second: got en=%b addr=%0d data=%h waw=%b, want 1 7 3ffff 1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.waw_err);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.pending_mask, bus.waw_err} !== {1'b0, 16'h0000, 1'b1}) begin
      miscompares++;
      $display("FAIL waw_sticky: got en=%b mask=%h waw=%b, want 0 0000 1",
               bus.wr_en, bus.pending_mask, bus.waw_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd5;
    bus.req0_data  = 18'h00011;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd5;
    bus.req1_data  = 18'h00022;
    step();
    bus.req0_addr  = 4'd6;
    bus.req0_data  = 18'h00033;
    bus.req1_valid = 1'b0;
    step();
    idle_inputs();
    vectors++;
    if ({bus.wr_en, bus.waw_err, bus.pending_mask} !== {1'b1, 1'b1, 16'h0060}) begin
      miscompares++;
      $display("FAIL rstmid_pre: got en=%b waw=%b mask=%h, want 1 1 0060",
               bus.wr_en, bus.waw_err, bus.pending_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.wr_en, bus.waw_err, bus.pending_mask, bus.req0_ready, bus.req1_ready} !==
        {1'b0, 1'b0, 16'h0000, 2'b11}) begin
      miscompares++;
      $display("FAIL rstmid_async: got en=%b waw=%b mask=%h ready=%b%b, want 0 0 0000 11",
               bus.wr_en, bus.waw_err, bus.pending_mask, bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({bus.wr_en, bus.pending_mask} !== '0) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: got en=%b mask=%h, want 0 0000",
                 k, bus.wr_en, bus.pending_mask);
      end
    end
  endtask

  task automatic test_zero_reg();
`ifdef REGFILE_WB_ZERO_REG_EN
    logic        exp_en   = 1'b0;
    logic [15:0] exp_mask = 16'h0000;
`else
    logic        exp_en   = 1'b1;
    logic [15:0] exp_mask = 16'h0001;
`endif
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd0;
    bus.req0_data  = 18'h12345;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got %b, want 1", bus.req0_ready);
    end
    step();
    idle_inputs();
    vectors++;
    if ({bus.wr_en, bus.pending_mask} !== {1'b0, exp_mask}) begin
      miscompares++;
      $display("FAIL zero_n1: got en=%b mask=%h, want 0 %h", bus.wr_en, bus.pending_mask, exp_mask);
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.pending_mask} !== {exp_en, exp_mask}) begin
      miscompares++;
      $display("FAIL zero_n2: got en=%b mask=%h, want %b %h",
               bus.wr_en, bus.pending_mask, exp_en, exp_mask);
    end
    if (exp_en) begin
      vectors++;
      if ({bus.wr_addr, bus.wr_data} !== {4'd0, 18'h12345}) begin
        miscompares++;
        $display("FAIL zero_write: got addr=%0d data=%h, want 0 12345", bus.wr_addr, bus.wr_data);
      end
    end
    step();
    vectors++;
    if ({bus.wr_en, bus.pending_mask} !== '0) begin
      miscompares++;
      $display("FAIL zero_n3: got en=%b mask=%h, want 0 0000", bus.wr_en, bus.pending_mask);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_age();
    test_waw();
    test_reset_mid();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
